// File: rtl/spi_txn_ctrl.sv
// Burst sequencer in front of a single-byte SPI master: accepts a command,
// frames the burst with slave select and moves tx/rx bytes through the master.
module spi_txn_ctrl #(
  parameter int unsigned NUM_SS   = 4,
  parameter int unsigned SS_W     = 2,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SS_W-1:0]   cmd_ss,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_cpol,
  input  logic              cmd_cpha,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [7:0]        tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [7:0]        rx_data,
  output logic              rx_last,
  output logic              txn_done,
  output logic              busy,
  output logic              m_cpol,
  output logic              m_cpha,
  output logic              m_start,
  output logic [7:0]        m_tx_data,
  input  logic [7:0]        m_rx_data,
  input  logic              m_done,
  input  logic              m_ready,
  output logic [NUM_SS-1:0] SS_n
);

  localparam int unsigned CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_SETUP, ST_FETCH, ST_START, ST_XFER, ST_RXOUT, ST_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [SS_W-1:0]    ss_q, ss_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cpol_q, cpol_d, cpha_q, cpha_d;
  logic               m_start_q, m_start_d;
  logic [7:0]         m_tx_data_q, m_tx_data_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_last_q, rx_last_d;
  logic               txn_done_q, txn_done_d;
  logic               busy_q, busy_d;
  logic [NUM_SS-1:0]  ss_n_q, ss_n_d;

  // Ready is withheld while reset is asserted so the host sees no handshake.
  assign cmd_ready = reset_n && (state_q == ST_IDLE);
  assign tx_ready  = (state_q == ST_FETCH);

  always_comb begin
    state_d     = state_q;
    ss_d        = ss_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    m_start_d   = 1'b0;
    m_tx_data_d = m_tx_data_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_last_d   = rx_last_q;
    txn_done_d  = 1'b0;
    ss_n_d      = ss_n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ss_d   = cmd_ss;
          rem_d  = cmd_len;
          cpol_d = cmd_cpol;
          cpha_d = cmd_cpha;
          if (cmd_len == '0) txn_done_d = 1'b1;
          else               state_d    = ST_PRE;
        end
      end
      ST_PRE: begin
        ss_n_d       = '1;
        ss_n_d[ss_q] = 1'b0;
        cnt_d        = '0;
        state_d      = ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = ST_FETCH;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_FETCH: begin
        if (tx_valid) begin
          m_tx_data_d = tx_data;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        if (m_ready) begin
          m_start_d = 1'b1;
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        if (m_done) begin
          rx_data_d  = m_rx_data;
          rx_valid_d = 1'b1;
          rx_last_d  = (rem_q == LEN_W'(1));
          rem_d      = rem_q - LEN_W'(1);
          state_d    = ST_RXOUT;
        end
      end
      ST_RXOUT: begin
        if (rx_ready) begin
          rx_valid_d = 1'b0;
          rx_last_d  = 1'b0;
          cnt_d      = '0;
          state_d    = (rem_q == '0) ? ST_HOLD : ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ss_n_d     = '1;
          txn_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ss_q        <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      m_start_q   <= 1'b0;
      m_tx_data_q <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_last_q   <= 1'b0;
      txn_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      ss_n_q      <= '1;
    end else begin
      state_q     <= state_d;
      ss_q        <= ss_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      m_start_q   <= m_start_d;
      m_tx_data_q <= m_tx_data_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_last_q   <= rx_last_d;
      txn_done_q  <= txn_done_d;
      busy_q      <= busy_d;
      ss_n_q      <= ss_n_d;
    end
  end

  assign m_cpol    = cpol_q;
  assign m_cpha    = cpha_q;
  assign m_start   = m_start_q;
  assign m_tx_data = m_tx_data_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_last   = rx_last_q;
  assign txn_done  = txn_done_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;

endmodule
